// File: rtl/intersection_pkg.sv
// Shared phase encodings, lamp patterns and the phase-to-lamps decode for the
// intersection scheduler.
package intersection_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6
  } phase_e;

  typedef enum logic {
    ROAD_NS = 1'b0,
    ROAD_EW = 1'b1
  } road_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } heads_t;

  function automatic heads_t decode_heads(phase_e p);
    heads_t h;
    h = '{ns: RED, ew: RED, walk: 1'b0};
    case (p)
      NS_GREEN:  h.ns   = GRN;
      NS_YELLOW: h.ns   = YEL;
      EW_GREEN:  h.ew   = GRN;
      EW_YELLOW: h.ew   = YEL;
      PED_WALK:  h.walk = 1'b1;
      default:   h.walk = 1'b0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase elapsed-cycle counter: clears on request, otherwise counts up and
// holds at SAT; done_o flags equality with the caller-supplied compare value.
module phase_timer #(
  parameter int unsigned W   = 5,
  parameter int unsigned SAT = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic [W-1:0] cmp_i,
  output logic [W-1:0] cnt_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != W'(SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == cmp_i);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road traffic signal controller with pedestrian walk phase, demand-driven
// green extension and registered Moore lamp outputs.
module intersection_phase_scheduler
  import intersection_pkg::*;
#(
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned GREEN_MAX = 32,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned WALK_T    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic [2:0] ns_lights,
  output logic [2:0] ew_lights,
  output logic       walk,
  output logic [2:0] phase
);

  localparam int unsigned CW = $clog2(GREEN_MAX + 1);

  phase_e          state_q, state_d;
  road_e           last_q, last_d;
  logic            ped_q, ped_d;
  logic [CW-1:0]   cnt, cmp;
  logic            done, min_ok;
  heads_t          heads_d;

  // In green states the compare value is the max-green point, so done doubles
  // as the "green has run to its limit" flag.
  always_comb begin
    case (state_q)
      NS_YELLOW, EW_YELLOW: cmp = CW'(YELLOW_T - 1);
      ALLRED_A, ALLRED_B:   cmp = CW'(ALLRED_T - 1);
      PED_WALK:             cmp = CW'(WALK_T - 1);
      default:              cmp = CW'(GREEN_MAX - 1);
    endcase
  end

  assign min_ok = (cnt >= CW'(GREEN_MIN - 1));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      NS_GREEN:
        if (min_ok && (ew_req || ped_q) && (!ns_req || done)) begin
          state_d = NS_YELLOW;
          last_d  = ROAD_NS;
        end
      NS_YELLOW: if (done) state_d = ALLRED_A;
      ALLRED_A:  if (done) state_d = ped_q ? PED_WALK : EW_GREEN;
      EW_GREEN:
        if (min_ok && (ns_req || ped_q) && (!ew_req || done)) begin
          state_d = EW_YELLOW;
          last_d  = ROAD_EW;
        end
      EW_YELLOW: if (done) state_d = ALLRED_B;
      ALLRED_B:  if (done) state_d = ped_q ? PED_WALK : NS_GREEN;
      PED_WALK:  if (done) state_d = (last_q == ROAD_NS) ? EW_GREEN : NS_GREEN;
      default:   state_d = NS_GREEN;
    endcase
  end

  // Entering the walk serves the request, so that clear outranks a new press.
  always_comb begin
    ped_d = ped_q;
    if (state_d == PED_WALK && state_q != PED_WALK) begin
      ped_d = 1'b0;
    end else if (ped_req && state_q != PED_WALK) begin
      ped_d = 1'b1;
    end
  end

  assign heads_d = decode_heads(state_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= NS_GREEN;
      last_q    <= ROAD_NS;
      ped_q     <= 1'b0;
      ns_lights <= GRN;
      ew_lights <= RED;
      walk      <= 1'b0;
      phase     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      ped_q     <= ped_d;
      ns_lights <= heads_d.ns;
      ew_lights <= heads_d.ew;
      walk      <= heads_d.walk;
      phase     <= 3'(state_d);
    end
  end

  phase_timer #(
    .W   (CW),
    .SAT (GREEN_MAX - 1)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_d != state_q),
    .cmp_i  (cmp),
    .cnt_o  (cnt),
    .done_o (done)
  );

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench for intersection_phase_scheduler: directed vector table,
// multi-cycle scenarios and randomized traffic against a behavioural model.
module tb_intersection_phase_scheduler;

  localparam int GMIN = 8;
  localparam int GMAX = 32;
  localparam int YT   = 4;
  localparam int AR   = 2;
  localparam int WT   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ns_req = 1'b0, ew_req = 1'b0, ped_req = 1'b0;
  logic [2:0] ns_lights, ew_lights, phase;
  logic       walk;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  // Behavioural model: phase number, cycles spent in it, pending walk, last road.
  int m_ph, m_el;
  bit m_ped, m_last_ew;

  always #5 clk = ~clk;

  intersection_phase_scheduler #(
    .GREEN_MIN (GMIN),
    .GREEN_MAX (GMAX),
    .YELLOW_T  (YT),
    .ALLRED_T  (AR),
    .WALK_T    (WT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ns_req    (ns_req),
    .ew_req    (ew_req),
    .ped_req   (ped_req),
    .ns_lights (ns_lights),
    .ew_lights (ew_lights),
    .walk      (walk),
    .phase     (phase)
  );

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Safety invariants every cycle.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (ns_lights != 3'b100 && ew_lights != 3'b100) begin
        failures++;
        $display("FAIL both_heads_nonred ns=%b ew=%b at %0t", ns_lights, ew_lights, $time);
      end
      checks++;
      if (walk && !(ns_lights == 3'b100 && ew_lights == 3'b100)) begin
        failures++;
        $display("FAIL walk_not_allred ns=%b ew=%b at %0t", ns_lights, ew_lights, $time);
      end
    end
  end

  function automatic logic [2:0] m_ns(int ph);
    return (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] m_ew(int ph);
    return (ph == 3) ? 3'b001 : (ph == 4) ? 3'b010 : 3'b100;
  endfunction

  task automatic model_step();
    int nx;
    if (rst) begin
      m_ph = 0; m_el = 0; m_ped = 0; m_last_ew = 0;
      return;
    end
    nx = m_ph;
    case (m_ph)
      0: if (m_el >= GMIN-1 && (ew_req || m_ped) && (!ns_req || m_el >= GMAX-1)) nx = 1;
      1: if (m_el == YT-1) nx = 2;
      2: if (m_el == AR-1) nx = m_ped ? 6 : 3;
      3: if (m_el >= GMIN-1 && (ns_req || m_ped) && (!ew_req || m_el >= GMAX-1)) nx = 4;
      4: if (m_el == YT-1) nx = 5;
      5: if (m_el == AR-1) nx = m_ped ? 6 : 0;
      6: if (m_el == WT-1) nx = m_last_ew ? 0 : 3;
      default: nx = 0;
    endcase
    if (m_ph == 0 && nx == 1) m_last_ew = 0;
    if (m_ph == 3 && nx == 4) m_last_ew = 1;
    if (nx == 6 && m_ph != 6) m_ped = 0;
    else if (ped_req && m_ph != 6) m_ped = 1;
    m_el = (nx != m_ph) ? 0 : m_el + 1;
    m_ph = nx;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    started = 1;
    check("model_phase", 8'(phase), 8'(m_ph));
    check("model_ns", 8'(ns_lights), 8'(m_ns(m_ph)));
    check("model_ew", 8'(ew_lights), 8'(m_ew(m_ph)));
    check("model_walk", 8'(walk), 8'(m_ph == 6));
  endtask

  task automatic apply(bit r, bit n, bit e, bit p, int cycles);
    rst = r; ns_req = n; ew_req = e; ped_req = p;
    repeat (cycles) tick();
  endtask

  task automatic run_while(logic [2:0] ph, int budget, output int n);
    n = 0;
    while (phase == ph && n < budget) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    bit         r, n, e, p;
    int         cyc;
    logic [2:0] ph, nsl, ewl;
    logic       wk;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int n;
    int walks;
    int e;

    // EW-only demand, rest in EW green, then contested exit at max green.
    tbl.push_back('{1,0,0,0,  3, 3'd0, 3'b001, 3'b100, 1'b0});
    tbl.push_back('{0,0,1,0,  7, 3'd0, 3'b001, 3'b100, 1'b0});
    tbl.push_back('{0,0,1,0,  1, 3'd1, 3'b010, 3'b100, 1'b0});
    tbl.push_back('{0,0,1,0,  3, 3'd1, 3'b010, 3'b100, 1'b0});
    tbl.push_back('{0,0,1,0,  1, 3'd2, 3'b100, 3'b100, 1'b0});
    tbl.push_back('{0,0,1,0,  1, 3'd2, 3'b100, 3'b100, 1'b0});
    tbl.push_back('{0,0,1,0,  1, 3'd3, 3'b100, 3'b001, 1'b0});
    tbl.push_back('{0,0,1,0, 50, 3'd3, 3'b100, 3'b001, 1'b0});
    tbl.push_back('{0,1,1,0,  1, 3'd4, 3'b100, 3'b010, 1'b0});
    tbl.push_back('{0,1,1,0,  3, 3'd4, 3'b100, 3'b010, 1'b0});
    tbl.push_back('{0,1,1,0,  1, 3'd5, 3'b100, 3'b100, 1'b0});
    tbl.push_back('{0,1,1,0,  2, 3'd0, 3'b001, 3'b100, 1'b0});
    tbl.push_back('{1,0,0,0,  1, 3'd0, 3'b001, 3'b100, 1'b0});
    tbl.push_back('{0,0,0,0,100, 3'd0, 3'b001, 3'b100, 1'b0});

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].n, tbl[i].e, tbl[i].p, tbl[i].cyc);
      check($sformatf("tbl%0d_phase", i), 8'(phase), 8'(tbl[i].ph));
      check($sformatf("tbl%0d_ns", i), 8'(ns_lights), 8'(tbl[i].nsl));
      check($sformatf("tbl%0d_ew", i), 8'(ew_lights), 8'(tbl[i].ewl));
      check($sformatf("tbl%0d_walk", i), 8'(walk), 8'(tbl[i].wk));
    end

    // Both roads busy: each green runs exactly GREEN_MAX cycles.
    apply(1, 0, 0, 0, 3);
    ns_req = 1; ew_req = 1; rst = 0;
    run_while(3'd0, 100, n);
    check("both_ns_green_len", 8'(n), 8'(GMAX));
    run_while(3'd1, 20, n);
    run_while(3'd2, 20, n);
    run_while(3'd3, 100, n);
    check("both_ew_green_len", 8'(n), 8'(GMAX));
    run_while(3'd4, 20, n);
    run_while(3'd5, 20, n);
    run_while(3'd0, 100, n);
    check("both_ns_green_len2", 8'(n), 8'(GMAX));

    // Pedestrian pulse at cnt=3 of NS green with no vehicle demand.
    apply(1, 0, 0, 0, 3);
    apply(0, 0, 0, 0, 3);
    apply(0, 0, 0, 1, 1);
    ped_req = 0;
    run_while(3'd0, 100, n);
    check("ped_green_len", 8'(n + 4), 8'(GMIN));
    run_while(3'd1, 20, n);
    check("ped_yellow_len", 8'(n), 8'(YT));
    run_while(3'd2, 20, n);
    check("ped_allred_len", 8'(n), 8'(AR));
    check("ped_walk_phase", 8'(phase), 8'd6);
    walks = 0;
    n = 0;
    while (phase == 3'd6 && n < 40) begin
      if (walk) walks++;
      tick();
      n++;
    end
    check("ped_walk_len", 8'(walks), 8'(WT));
    check("ped_after_walk", 8'(phase), 8'd3);

    // Reset during EW yellow with a pending walk request drops the request.
    apply(0, 0, 0, 1, 1);
    ped_req = 0;
    n = 0;
    while (phase != 3'd4 && n < 60) begin
      tick();
      n++;
    end
    check("rst_reach_ew_yellow", 8'(phase), 8'd4);
    apply(1, 0, 0, 0, 1);
    check("rst_mid_phase", 8'(phase), 8'd0);
    check("rst_mid_ns", 8'(ns_lights), 8'(3'b001));
    rst = 0;
    walks = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (walk) walks++;
    end
    check("rst_dropped_walk", 8'(walks), 8'd0);
    check("rst_idle_phase", 8'(phase), 8'd0);

    // Randomized traffic, including occasional resets.
    apply(1, 0, 0, 0, 2);
    for (int i = 0; i < 4000; i++) begin
      if (i % 16 == 0) begin
        ns_req = ($urandom_range(0, 3) != 0);
        ew_req = ($urandom_range(0, 2) != 0);
      end
      ped_req = ($urandom_range(0, 29) == 0);
      rst     = ($urandom_range(0, 599) == 0);
      tick();
    end
    e = failures;
    rst = 0; ns_req = 0; ew_req = 0; ped_req = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
